// File: rtl/spi_cmd_scheduler.sv
// Command scheduler for the SPI master: FIFO-buffered words, one exe pulse per word, single response slot.
// Optional BUSY watchdog is compiled in when SPI_SCHED_TIMEOUT_EN is defined.
module spi_cmd_scheduler #(
    parameter int DATA_WIDTH     = 24,
    parameter int FIFO_DEPTH     = 8,
    parameter int GAP_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [DATA_WIDTH-1:0]        cmd_data,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [DATA_WIDTH-1:0]        rsp_data,
    output logic                         rsp_err,
    output logic                         spi_exe,
    output logic [DATA_WIDTH-1:0]        tx_data,
    input  logic [DATA_WIDTH-1:0]        rx_data,
    input  logic                         spi_done,
    output logic                         busy,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW:0]           wr_ptr_q, rd_ptr_q;
    logic [1:0]            state_q, state_d;
    logic [GW-1:0]         gap_cnt_q, gap_cnt_d;
    logic                  spi_exe_q, spi_exe_d;
    logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic                  push, pop, empty, slot_free, timeout_hit;

    assign fifo_level = wr_ptr_q - rd_ptr_q;
    assign empty      = (fifo_level == '0);
    assign cmd_ready  = (fifo_level != FULL_LVL);
    assign push       = cmd_valid && cmd_ready;
    // The slot counts as free on the edge that consumes the held response.
    assign slot_free  = !rsp_valid_q || rsp_ready;
    assign busy       = (state_q != S_IDLE) || !empty;

    assign spi_exe   = spi_exe_q;
    assign tx_data   = tx_data_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;

`ifdef SPI_SCHED_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TW-1:0] tmo_cnt_q;
    logic          rsp_err_q, rsp_err_d;

    assign timeout_hit = (state_q == S_BUSY) && !spi_done && (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));
    assign rsp_err     = rsp_err_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tmo_cnt_q <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            tmo_cnt_q <= (state_q == S_BUSY) ? tmo_cnt_q + TW'(1) : '0;
            rsp_err_q <= rsp_err_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign rsp_err     = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        gap_cnt_d   = gap_cnt_q;
        spi_exe_d   = 1'b0;
        tx_data_d   = tx_data_q;
        rsp_valid_d = rsp_valid_q && !rsp_ready;
        rsp_data_d  = rsp_data_q;
        pop         = 1'b0;
`ifdef SPI_SCHED_TIMEOUT_EN
        rsp_err_d   = rsp_err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (!empty && slot_free) begin
                    pop       = 1'b1;
                    spi_exe_d = 1'b1;
                    tx_data_d = mem_q[rd_ptr_q[AW-1:0]];
                    state_d   = S_BUSY;
                end
            end
            S_BUSY: begin
                if (spi_done || timeout_hit) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = spi_done ? rx_data : '0;
`ifdef SPI_SCHED_TIMEOUT_EN
                    rsp_err_d   = !spi_done;
`endif
                    gap_cnt_d   = '0;
                    state_d     = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
                end
            end
            S_GAP: begin
                if (gap_cnt_q == GW'(GAP_CYCLES - 1)) state_d = S_IDLE;
                else gap_cnt_d = gap_cnt_q + GW'(1);
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            state_q     <= S_IDLE;
            gap_cnt_q   <= '0;
            spi_exe_q   <= 1'b0;
            tx_data_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            state_q     <= state_d;
            gap_cnt_q   <= gap_cnt_d;
            spi_exe_q   <= spi_exe_d;
            tx_data_q   <= tx_data_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= cmd_data;
    end

endmodule

// File: tb/tb_spi_cmd_scheduler.sv
// Scoreboard bench for spi_cmd_scheduler: SPI master model answers tx ^ MASK after a fixed latency.
// A second instance with GAP_CYCLES=0 is driven by hand.
module tb_spi_cmd_scheduler;
    localparam int DW   = 24;
    localparam int GAP  = 4;
    localparam int LAT  = 8;
    localparam int TMO  = 64;
    localparam logic [DW-1:0] MASK = 24'hB7F7A6;

    typedef struct packed { logic [DW-1:0] data; logic err; } rsp_t;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          cmd_valid = 1'b0, cmd_ready;
    logic [DW-1:0] cmd_data = '0;
    logic          rsp_valid, rsp_ready = 1'b0, rsp_err;
    logic [DW-1:0] rsp_data, tx_data;
    logic [DW-1:0] rx_data = '0;
    logic          spi_exe, spi_done, busy;
    logic          mdl_done = 1'b0, man_done = 1'b0;
    logic [3:0]    fifo_level;

    logic          v0 = 1'b0, rdy0, rsp_valid0, rsp_ready0 = 1'b1, rsp_err0, exe0, done0 = 1'b0, busy0;
    logic [DW-1:0] d0 = '0, rsp_data0, tx0, rx0 = '0;
    logic [3:0]    lvl0;

    int   checks = 0, errors = 0;
    int   cyc = 0, done_cyc = -1000, reset_epoch = 0;
    logic model_on = 1'b1;
    rsp_t exp_rsp[$];
    logic [DW-1:0] exp_tx[$];

    assign spi_done = mdl_done | man_done;

    always #5 clock = ~clock;

    spi_cmd_scheduler #(.DATA_WIDTH(DW), .FIFO_DEPTH(8), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)) u_dut (
        .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .spi_exe(spi_exe), .tx_data(tx_data), .rx_data(rx_data), .spi_done(spi_done),
        .busy(busy), .fifo_level(fifo_level));

    spi_cmd_scheduler #(.DATA_WIDTH(DW), .FIFO_DEPTH(8), .GAP_CYCLES(0), .TIMEOUT_CYCLES(TMO)) u_dut0 (
        .clock(clock), .reset(reset), .cmd_valid(v0), .cmd_ready(rdy0), .cmd_data(d0),
        .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0), .rsp_data(rsp_data0), .rsp_err(rsp_err0),
        .spi_exe(exe0), .tx_data(tx0), .rx_data(rx0), .spi_done(done0),
        .busy(busy0), .fifo_level(lvl0));

    // Inputs change on the falling edge; everything is sampled 1 time unit before the rising edge.
    initial begin
        forever begin
            @(negedge clock); #4;
            cyc++;
            if (!reset) continue;
            if (cmd_valid && cmd_ready) begin
                rsp_t e;
                e.data = model_on ? (cmd_data ^ MASK) : '0;
                e.err  = !model_on;
                exp_tx.push_back(cmd_data);
                exp_rsp.push_back(e);
            end
            if (spi_done) done_cyc = cyc;
            if (spi_exe) begin
                checks++;
                if (exp_tx.size() == 0) begin
                    errors++; $display("FAIL exe_unexpected tx_data=%h (no command queued)", tx_data);
                end else begin
                    logic [DW-1:0] et;
                    et = exp_tx.pop_front();
                    if (tx_data !== et) begin errors++; $display("FAIL exe_tx_data got %h expected %h", tx_data, et); end
                end
                checks++;
                if (cyc - done_cyc < GAP + 1) begin
                    errors++; $display("FAIL exe_gap got %0d cycles after done expected >= %0d", cyc - done_cyc, GAP + 1);
                end
            end
            if (rsp_valid && rsp_ready) begin
                checks++;
                if (exp_rsp.size() == 0) begin
                    errors++; $display("FAIL rsp_unexpected data=%h err=%b", rsp_data, rsp_err);
                end else begin
                    rsp_t er;
                    er = exp_rsp.pop_front();
                    if (rsp_data !== er.data || rsp_err !== er.err) begin
                        errors++; $display("FAIL rsp_order got %h/%b expected %h/%b", rsp_data, rsp_err, er.data, er.err);
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clock); #4;
            if (spi_exe && model_on) begin
                logic [DW-1:0] cap;
                int            ep;
                cap = tx_data;
                ep  = reset_epoch;
                repeat (LAT) @(negedge clock);
                if (ep == reset_epoch) begin
                    checks++;
                    if (tx_data !== cap) begin errors++; $display("FAIL tx_stable got %h expected %h", tx_data, cap); end
                end
                rx_data  = cap ^ MASK;
                mdl_done = 1'b1;
                @(negedge clock);
                mdl_done = 1'b0;
            end
        end
    end

    task automatic push_cmd(input logic [DW-1:0] d);
        int n = 0;
        @(negedge clock); cmd_valid = 1'b1; cmd_data = d; #4;
        while (!cmd_ready && n < 300) begin @(negedge clock); #4; n++; end
        checks++;
        if (!cmd_ready) begin errors++; $display("FAIL push_accept cmd_ready=%b expected 1 within 300 cycles", cmd_ready); end
    endtask

    task automatic end_cmd();
        @(negedge clock); cmd_valid = 1'b0; #4;
    endtask

    task automatic wait_exe(input string tag);
        int n = 0;
        while (!spi_exe && n < 100) begin @(negedge clock); #4; n++; end
        checks++;
        if (!spi_exe) begin errors++; $display("FAIL %s_exe spi_exe=%b expected 1 within 100 cycles", tag, spi_exe); end
    endtask

    task automatic drain(input string tag);
        int n = 0;
        rsp_ready = 1'b1;
        while ((busy || rsp_valid || exp_rsp.size() != 0) && n < 600) begin @(negedge clock); #4; n++; end
        checks++;
        if (busy || exp_rsp.size() != 0) begin
            errors++; $display("FAIL %s_drain busy=%b pending=%0d expected 0/0", tag, busy, exp_rsp.size());
        end
    endtask

    task automatic test_reset();
        @(negedge clock); #4;
        checks++;
        if (cmd_ready !== 1'b1 || spi_exe !== 1'b0 || tx_data !== '0 || busy !== 1'b0 || fifo_level !== 4'd0) begin
            errors++; $display("FAIL reset_ctrl ready=%b exe=%b tx=%h busy=%b lvl=%0d expected 1/0/0/0/0", cmd_ready, spi_exe, tx_data, busy, fifo_level);
        end
        checks++;
        if (rsp_valid !== 1'b0 || rsp_data !== '0 || rsp_err !== 1'b0) begin
            errors++; $display("FAIL reset_rsp valid=%b data=%h err=%b expected 0/0/0", rsp_valid, rsp_data, rsp_err);
        end
        @(negedge clock); reset = 1'b1;
        repeat (2) @(negedge clock);
    endtask

    task automatic test_single();
        int n = 0;
        rsp_ready = 1'b0;
        @(negedge clock); cmd_valid = 1'b1; cmd_data = 24'hA5C3F0; #4;
        checks++;
        if (cmd_ready !== 1'b1) begin errors++; $display("FAIL single_ready got %b expected 1", cmd_ready); end
        @(negedge clock); cmd_valid = 1'b0; #4;
        checks++;
        if (spi_exe !== 1'b0 || fifo_level !== 4'd1) begin
            errors++; $display("FAIL single_queued exe=%b lvl=%0d expected 0/1", spi_exe, fifo_level);
        end
        @(negedge clock); #4;
        checks++;
        if (spi_exe !== 1'b1 || tx_data !== 24'hA5C3F0 || fifo_level !== 4'd0 || busy !== 1'b1) begin
            errors++; $display("FAIL single_exe exe=%b tx=%h lvl=%0d busy=%b expected 1/a5c3f0/0/1", spi_exe, tx_data, fifo_level, busy);
        end
        @(negedge clock); #4;
        checks++;
        if (spi_exe !== 1'b0) begin errors++; $display("FAIL single_pulse_width exe=%b expected 0", spi_exe); end
        while (!spi_done && n < 50) begin @(negedge clock); #4; n++; end
        checks++;
        if (spi_done !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++; $display("FAIL single_done done=%b rsp_valid=%b expected 1/0", spi_done, rsp_valid);
        end
        @(negedge clock); #4;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== 24'h123456 || rsp_err !== 1'b0) begin
            errors++; $display("FAIL single_rsp valid=%b data=%h err=%b expected 1/123456/0", rsp_valid, rsp_data, rsp_err);
        end
        @(negedge clock); rsp_ready = 1'b1; #4;
        @(negedge clock); #4;
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_clear rsp_valid=%b expected 0", rsp_valid); end
        drain("single");
    endtask

    task automatic test_burst();
        int n = 0;
        rsp_ready = 1'b1;
        push_cmd(24'h100000); end_cmd();
        wait_exe("burst");
        for (int i = 1; i <= 8; i++) push_cmd(24'h100000 + DW'(i));
        @(negedge clock); cmd_valid = 1'b1; cmd_data = 24'h100009; #4;
        checks++;
        if (cmd_ready !== 1'b0 || fifo_level !== 4'd8) begin
            errors++; $display("FAIL burst_full ready=%b lvl=%0d expected 0/8", cmd_ready, fifo_level);
        end
        while (!cmd_ready && n < 300) begin @(negedge clock); #4; n++; end
        checks++;
        if (cmd_ready !== 1'b1 || fifo_level !== 4'd7) begin
            errors++; $display("FAIL burst_ninth ready=%b lvl=%0d expected 1/7", cmd_ready, fifo_level);
        end
        end_cmd();
        drain("burst");
    endtask

    task automatic test_backpressure();
        int n = 0;
        logic [DW-1:0] hold;
        rsp_ready = 1'b0;
        push_cmd(24'h00C0DE); push_cmd(24'h00BEEF); push_cmd(24'h00FACE); end_cmd();
        while (!rsp_valid && n < 100) begin @(negedge clock); #4; n++; end
        hold = rsp_data;
        checks++;
        if (rsp_valid !== 1'b1 || hold !== (24'h00C0DE ^ MASK)) begin
            errors++; $display("FAIL bp_first valid=%b data=%h expected 1/%h", rsp_valid, hold, 24'h00C0DE ^ MASK);
        end
        for (int i = 0; i < 50; i++) begin
            @(negedge clock); #4;
            checks++;
            if (spi_exe !== 1'b0 || rsp_valid !== 1'b1 || rsp_data !== hold) begin
                errors++; $display("FAIL bp_hold cycle %0d exe=%b valid=%b data=%h expected 0/1/%h", i, spi_exe, rsp_valid, rsp_data, hold);
            end
        end
        @(negedge clock); rsp_ready = 1'b1; #4;
        @(negedge clock); #4;
        checks++;
        if (spi_exe !== 1'b1 || tx_data !== 24'h00BEEF) begin
            errors++; $display("FAIL bp_resume exe=%b tx=%h expected 1/00beef", spi_exe, tx_data);
        end
        drain("bp");
    endtask

    task automatic test_reset_mid();
        logic saw_done = 1'b0, bad_rsp = 1'b0;
        rsp_ready = 1'b1;
        push_cmd(24'h000001); push_cmd(24'h000002); push_cmd(24'h000003); push_cmd(24'h000004); end_cmd();
        checks++;
        if (fifo_level !== 4'd3 || busy !== 1'b1) begin
            errors++; $display("FAIL rstmid_pre lvl=%0d busy=%b expected 3/1", fifo_level, busy);
        end
        @(negedge clock); reset = 1'b0; reset_epoch++; #4;
        checks++;
        if (fifo_level !== 4'd0 || cmd_ready !== 1'b1 || spi_exe !== 1'b0 || tx_data !== '0 || busy !== 1'b0) begin
            errors++; $display("FAIL rstmid_ctrl lvl=%0d ready=%b exe=%b tx=%h busy=%b expected 0/1/0/0/0", fifo_level, cmd_ready, spi_exe, tx_data, busy);
        end
        checks++;
        if (rsp_valid !== 1'b0 || rsp_data !== '0 || rsp_err !== 1'b0) begin
            errors++; $display("FAIL rstmid_rsp valid=%b data=%h err=%b expected 0/0/0", rsp_valid, rsp_data, rsp_err);
        end
        exp_tx.delete();
        exp_rsp.delete();
        @(negedge clock); reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock); #4;
            if (spi_done) saw_done = 1'b1;
            if (rsp_valid || spi_exe || busy) bad_rsp = 1'b1;
        end
        checks++;
        if (!saw_done || bad_rsp) begin
            errors++; $display("FAIL rstmid_stray saw_done=%b activity=%b expected 1/0", saw_done, bad_rsp);
        end
    endtask

    task automatic test_gap_zero();
        @(negedge clock); v0 = 1'b1; d0 = 24'h0000AA; #4;
        @(negedge clock); d0 = 24'h0000BB; #4;
        checks++;
        if (exe0 !== 1'b0) begin errors++; $display("FAIL gap0_early exe=%b expected 0", exe0); end
        @(negedge clock); v0 = 1'b0; #4;
        checks++;
        if (exe0 !== 1'b1 || tx0 !== 24'h0000AA || lvl0 !== 4'd1) begin
            errors++; $display("FAIL gap0_exe1 exe=%b tx=%h lvl=%0d expected 1/0000aa/1", exe0, tx0, lvl0);
        end
        @(negedge clock); #4;
        @(negedge clock); done0 = 1'b1; rx0 = 24'h111111; #4;
        @(negedge clock); done0 = 1'b0; #4;
        checks++;
        if (rsp_valid0 !== 1'b1 || rsp_data0 !== 24'h111111 || exe0 !== 1'b0) begin
            errors++; $display("FAIL gap0_rsp1 valid=%b data=%h exe=%b expected 1/111111/0", rsp_valid0, rsp_data0, exe0);
        end
        @(negedge clock); #4;
        checks++;
        if (rsp_valid0 !== 1'b0 || exe0 !== 1'b1 || tx0 !== 24'h0000BB || lvl0 !== 4'd0) begin
            errors++; $display("FAIL gap0_exe2 valid=%b exe=%b tx=%h lvl=%0d expected 0/1/0000bb/0", rsp_valid0, exe0, tx0, lvl0);
        end
        @(negedge clock); done0 = 1'b1; rx0 = 24'h222222; #4;
        @(negedge clock); done0 = 1'b0; #4;
        checks++;
        if (rsp_valid0 !== 1'b1 || rsp_data0 !== 24'h222222 || rsp_err0 !== 1'b0) begin
            errors++; $display("FAIL gap0_rsp2 valid=%b data=%h err=%b expected 1/222222/0", rsp_valid0, rsp_data0, rsp_err0);
        end
        @(negedge clock); #4;
        checks++;
        if (rsp_valid0 !== 1'b0 || busy0 !== 1'b0) begin
            errors++; $display("FAIL gap0_idle valid=%b busy=%b expected 0/0", rsp_valid0, busy0);
        end
    endtask

`ifdef SPI_SCHED_TIMEOUT_EN
    task automatic test_timeout();
        model_on  = 1'b0;
        rsp_ready = 1'b0;
        push_cmd(24'h0F0F0F); end_cmd();
        wait_exe("tmo");
        for (int k = 1; k <= TMO; k++) begin
            @(negedge clock); #4;
            if (k < TMO && rsp_valid) begin
                checks++; errors++; $display("FAIL tmo_early rsp_valid=1 at %0d cycles expected 0", k);
            end
        end
        checks++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_data !== '0) begin
            errors++; $display("FAIL tmo_rsp valid=%b err=%b data=%h expected 1/1/0", rsp_valid, rsp_err, rsp_data);
        end
        @(negedge clock); man_done = 1'b1; rx_data = 24'hDEAD01; #4;
        @(negedge clock); man_done = 1'b0; #4;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_data !== '0) begin
            errors++; $display("FAIL tmo_late valid=%b err=%b data=%h expected 1/1/0", rsp_valid, rsp_err, rsp_data);
        end
        drain("tmo");
        model_on = 1'b1;
    endtask
`endif

    initial begin
        #400000;
        $display("FAIL watchdog simulation did not complete within time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_backpressure();
        test_reset_mid();
        test_gap_zero();
`ifdef SPI_SCHED_TIMEOUT_EN
        test_timeout();
`endif
        checks++;
        if (exp_tx.size() != 0 || exp_rsp.size() != 0) begin
            errors++; $display("FAIL scoreboard_leftover tx=%0d rsp=%0d expected 0/0", exp_tx.size(), exp_rsp.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
